uart_rx_cfg: RTL and testbench

// Parametrised UART receiver, successor to the fixed 8N1 receiver on the board-to-host serial link.

---
 rtl/uart_rx_cfg.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with 16x oversampling and
// 3-sample majority vote. Flags parity and framing errors and delivers each
// character with a single-cycle valid pulse (no backpressure).
module uart_rx_cfg #(
    parameter int CLK_HZ     = 125_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS + 1);

    localparam logic [DCW-1:0] DIV_LAST  = DCW'(DIV - 1);
    localparam logic [SCW-1:0] SMP_LAST  = SCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] SMP_A     = SCW'(M - 1);
    localparam logic [SCW-1:0] SMP_B     = SCW'(M);
    localparam logic [SCW-1:0] SMP_C     = SCW'(M + 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]           settle_q;
    logic [DCW-1:0]       div_cnt_q;
    logic [SCW-1:0]       smp_cnt_q;
    logic                 vote0_q, vote1_q;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;

    logic fall, start_fall, tick, decide, bit_val;

    // The settle counter masks the 1->0 step seen while the reset-time 1s
    // drain out of the synchroniser, so a line held low at reset release
    // does not look like a start edge.
    assign fall       = (settle_q == 2'd3) && rx_prev_q && !rx_sync_q;
    assign start_fall = (state_q == S_IDLE) && fall;
    assign tick       = (div_cnt_q == DIV_LAST);
    assign decide     = tick && (smp_cnt_q == SMP_C);
    assign bit_val    = (vote0_q & vote1_q) | (vote0_q & rx_sync_q) | (vote1_q & rx_sync_q);

    // Two-flop synchroniser, edge register and post-reset settle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            settle_q  <= 2'd0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
        end
    end

    // Tick divider and per-bit sample counter, realigned on the start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            smp_cnt_q <= '0;
        end else if (start_fall) begin
            div_cnt_q <= '0;
            smp_cnt_q <= '0;
        end else if (tick) begin
            div_cnt_q <= '0;
            smp_cnt_q <= (smp_cnt_q == SMP_LAST) ? '0 : smp_cnt_q + 1'b1;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    // Capture the first two mid-bit samples; the third is live at the decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote0_q <= 1'b0;
            vote1_q <= 1'b0;
        end else if (tick) begin
            if (smp_cnt_q == SMP_A) vote0_q <= rx_sync_q;
            if (smp_cnt_q == SMP_B) vote1_q <= rx_sync_q;
        end
    end

    // FSM state, frame accumulators and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Next-state and output logic; FSM returns to IDLE at the last stop
    // decision (mid-bit) so an early next start edge is still caught
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        data_out_d   = data_out_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d   = S_START;
                    bit_cnt_d = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                end
            end
            S_START: begin
                if (decide) state_d = bit_val ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (decide) begin
                    // odd parity wants an overall XOR of 1, even wants 0
                    perr_d  = (PARITY == 1) ? ~((^shift_q) ^ bit_val) : ((^shift_q) ^ bit_val);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    ferr_d = ferr_q | ~bit_val;
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d      = S_IDLE;
                        valid_d      = 1'b1;
                        data_out_d   = shift_q;
                        parity_err_d = perr_q;
                        frame_err_d  = ferr_q | ~bit_val;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data_out   = data_out_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: three receiver configurations on separate lines,
// directed frames, scoreboard queues popped by a valid-driven monitor.
module tb_uart_rx_cfg;

    // 14.7456 MHz / (115200*16) gives a divider of 8, so one bit is 128 clk
    localparam int TB_CLK = 14_745_600;
    localparam int BCLK   = 128;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk, rst_n;
    logic rx_a, rx_b, rx_c;
    logic [7:0] dout_a;
    logic [6:0] dout_b;
    logic [7:0] dout_c;
    logic valid_a, valid_b, valid_c;
    logic perr_a, perr_b, perr_c;
    logic ferr_a, ferr_b, ferr_c;
    logic busy_a, busy_b, busy_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int checks = 0;
    int errors = 0;

    uart_rx_cfg #(.CLK_HZ(TB_CLK)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .data_out(dout_a), .valid(valid_a),
        .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a)
    );

    uart_rx_cfg #(.CLK_HZ(TB_CLK), .DATA_BITS(7), .PARITY(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .data_out(dout_b), .valid(valid_b),
        .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b)
    );

    uart_rx_cfg #(.CLK_HZ(TB_CLK), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .rx(rx_c), .data_out(dout_c), .valid(valid_c),
        .parity_err(perr_c), .frame_err(ferr_c), .busy(busy_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_valid(input int sel, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        int   n;
        n = (sel == 0) ? q_a.size() : (sel == 1) ? q_b.size() : q_c.size();
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL unexpected_valid inst=%0d: got data %h, expected no valid", sel, d);
        end else begin
            case (sel)
                0:       e = q_a.pop_front();
                1:       e = q_b.pop_front();
                default: e = q_c.pop_front();
            endcase
            check_eq($sformatf("inst%0d_data", sel), d, e.data);
            check_eq($sformatf("inst%0d_parity_err", sel), {8'b0, pe}, {8'b0, e.perr});
            check_eq($sformatf("inst%0d_frame_err", sel), {8'b0, fe}, {8'b0, e.ferr});
        end
    endtask

    // Monitor: every valid pulse consumes one expected character
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_a) check_valid(0, {1'b0, dout_a}, perr_a, ferr_a);
            if (valid_b) check_valid(1, {2'b0, dout_b}, perr_b, ferr_b);
            if (valid_c) check_valid(2, {1'b0, dout_c}, perr_c, ferr_c);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // One frame: start, data LSB first, optional parity, stop bit(s), idle gap.
    // glitch_bit >= 0 pulls the line low for one tick around that data bit's middle.
    task automatic send(input int sel, input logic [8:0] d, input int nbits,
                        input int has_par, input logic pbit, input int nstop,
                        input logic stopv, input int bclk, input int gap_bits,
                        input int glitch_bit);
        set_rx(sel, 1'b0);
        wait_clks(bclk);
        for (int i = 0; i < nbits; i++) begin
            set_rx(sel, d[i]);
            if (i == glitch_bit) begin
                wait_clks(68);
                set_rx(sel, 1'b0);
                wait_clks(8);
                set_rx(sel, d[i]);
                wait_clks(bclk - 76);
            end else begin
                wait_clks(bclk);
            end
        end
        if (has_par != 0) begin
            set_rx(sel, pbit);
            wait_clks(bclk);
        end
        for (int s = 0; s < nstop; s++) begin
            set_rx(sel, stopv);
            wait_clks(bclk);
        end
        set_rx(sel, 1'b1);
        wait_clks(gap_bits * bclk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_a_data"}, {1'b0, dout_a}, 9'h000);
        check_eq({tag, "_a_flags"}, {6'b0, valid_a, perr_a, ferr_a}, 9'h000);
        check_eq({tag, "_a_busy"}, {8'b0, busy_a}, 9'h000);
        check_eq({tag, "_b_data"}, {2'b0, dout_b}, 9'h000);
        check_eq({tag, "_b_flags"}, {5'b0, valid_b, perr_b, ferr_b, busy_b}, 9'h000);
        check_eq({tag, "_c_data"}, {1'b0, dout_c}, 9'h000);
        check_eq({tag, "_c_flags"}, {5'b0, valid_c, perr_c, ferr_c, busy_c}, 9'h000);
    endtask

    initial begin
        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        rx_c  = 1'b1;
        wait_clks(5);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        wait_clks(3 * BCLK);

        // T1: 8N1 0xA5
        q_a.push_back('{data: 9'h0A5, perr: 1'b0, ferr: 1'b0});
        send(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, BCLK, 2, -1);

        // T2: 7E1, 0x03 has even ones, so parity bit 1 is wrong and 0 is right
        q_b.push_back('{data: 9'h003, perr: 1'b1, ferr: 1'b0});
        send(1, 9'h003, 7, 1, 1'b1, 1, 1'b1, BCLK, 2, -1);
        q_b.push_back('{data: 9'h003, perr: 1'b0, ferr: 1'b0});
        send(1, 9'h003, 7, 1, 1'b0, 1, 1'b1, BCLK, 2, -1);

        // T3: bad stop bit, then a clean frame
        q_a.push_back('{data: 9'h03C, perr: 1'b0, ferr: 1'b1});
        send(0, 9'h03C, 8, 0, 1'b0, 1, 1'b0, BCLK, 2, -1);
        q_a.push_back('{data: 9'h00F, perr: 1'b0, ferr: 1'b0});
        send(0, 9'h00F, 8, 0, 1'b0, 1, 1'b1, BCLK, 2, -1);

        // T4: short low glitch is a false start; busy rises then falls
        rx_a = 1'b0;
        wait_clks(20);
        check_eq("false_start_busy_high", {8'b0, busy_a}, 9'h001);
        wait_clks(4);
        rx_a = 1'b1;
        wait_clks(120);
        check_eq("false_start_busy_low", {8'b0, busy_a}, 9'h000);
        wait_clks(2 * BCLK);
        // single-tick mid-bit glitch inside 0xFF is outvoted
        q_a.push_back('{data: 9'h0FF, perr: 1'b0, ferr: 1'b0});
        send(0, 9'h0FF, 8, 0, 1'b0, 1, 1'b1, BCLK, 2, 3);

        // T5: 8N2 back-to-back at +2% and -2% baud
        q_c.push_back('{data: 9'h055, perr: 1'b0, ferr: 1'b0});
        send(2, 9'h055, 8, 0, 1'b0, 2, 1'b1, 125, 0, -1);
        q_c.push_back('{data: 9'h0AA, perr: 1'b0, ferr: 1'b0});
        send(2, 9'h0AA, 8, 0, 1'b0, 2, 1'b1, 125, 2, -1);
        q_c.push_back('{data: 9'h055, perr: 1'b0, ferr: 1'b0});
        send(2, 9'h055, 8, 0, 1'b0, 2, 1'b1, 131, 0, -1);
        q_c.push_back('{data: 9'h0AA, perr: 1'b0, ferr: 1'b0});
        send(2, 9'h0AA, 8, 0, 1'b0, 2, 1'b1, 131, 2, -1);

        // T6: reset in the middle of data bit 4 of 0x77 discards the frame
        rx_a = 1'b0;
        wait_clks(BCLK);
        for (int i = 0; i < 4; i++) begin
            rx_a = (8'h77 >> i) & 8'h01;
            wait_clks(BCLK);
        end
        rx_a = 1'b1;
        wait_clks(BCLK / 2);
        rst_n = 1'b0;
        wait_clks(4);
        check_idle_outputs("midframe_reset");
        rst_n = 1'b1;
        wait_clks(3 * BCLK);
        check_eq("post_reset_no_busy", {8'b0, busy_a}, 9'h000);
        q_a.push_back('{data: 9'h012, perr: 1'b0, ferr: 1'b0});
        send(0, 9'h012, 8, 0, 1'b0, 1, 1'b1, BCLK, 2, -1);

        // Drain: every expected character must have been delivered
        for (int i = 0; i < 4000 && (q_a.size() + q_b.size() + q_c.size()) != 0; i++)
            @(negedge clk);
        check_eq("pending_a", 9'(q_a.size()), 9'h000);
        check_eq("pending_b", 9'(q_b.size()), 9'h000);
        check_eq("pending_c", 9'(q_c.size()), 9'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
